// File: rtl/vga_timing_prog.sv
// Programmable VGA/DVI raster timing generator with frame-synchronous reconfiguration.
// Optional frame counter port pair is built only when VGA_FRAME_COUNT_EN is defined.
module vga_timing_prog #(
    parameter int HW        = 11,
    parameter int VW        = 10,
    parameter int LOOKAHEAD = 4,
    parameter int DEF_HACT  = 640,
    parameter int DEF_HFP   = 16,
    parameter int DEF_HSYNC = 96,
    parameter int DEF_HBP   = 48,
    parameter int DEF_VACT  = 480,
    parameter int DEF_VFP   = 10,
    parameter int DEF_VSYNC = 2,
    parameter int DEF_VBP   = 33,
    parameter int DEF_HPOL  = 0,
    parameter int DEF_VPOL  = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            pix_en,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [4*HW-1:0] cfg_h,
    input  logic [4*VW-1:0] cfg_v,
    input  logic [1:0]      cfg_pol,
    output logic            cfg_pending,
    output logic            hsync,
    output logic            vsync,
    output logic            blank,
    output logic            de,
    output logic [HW-1:0]   x_pos,
    output logic [VW-1:0]   y_pos,
    output logic            line_pulse,
    output logic            frame_pulse,
    output logic            fetch_pulse
`ifdef VGA_FRAME_COUNT_EN
    ,
    input  logic            frame_cnt_clr,
    output logic [15:0]     frame_cnt
`endif
);

    localparam logic [HW-1:0] H1 = HW'(1);
    localparam logic [VW-1:0] V1 = VW'(1);
    localparam logic [HW-1:0] LA = HW'(LOOKAHEAD);

    localparam logic [4*HW-1:0] DEF_H = {
        HW'(DEF_HACT), HW'(DEF_HFP), HW'(DEF_HSYNC), HW'(DEF_HBP)
    };
    localparam logic [4*VW-1:0] DEF_V = {
        VW'(DEF_VACT), VW'(DEF_VFP), VW'(DEF_VSYNC), VW'(DEF_VBP)
    };
    localparam logic [1:0] DEF_POL = {1'(DEF_HPOL), 1'(DEF_VPOL)};

    function automatic logic [HW-1:0] hsum(input logic [4*HW-1:0] h);
        return h[4*HW-1-:HW] + h[3*HW-1-:HW] + h[2*HW-1-:HW] + h[HW-1:0];
    endfunction

    function automatic logic [VW-1:0] vsum(input logic [4*VW-1:0] v);
        return v[4*VW-1-:VW] + v[3*VW-1-:VW] + v[2*VW-1-:VW] + v[VW-1:0];
    endfunction

    // applied and pending configuration
    logic [4*HW-1:0] ah_q, ah_d, ph_q, ph_d;
    logic [4*VW-1:0] av_q, av_d, pv_q, pv_d;
    logic [1:0]      apol_q, apol_d, ppol_q, ppol_d;
    logic            pend_q, pend_d;

    // raster counters
    logic [HW-1:0] x_q, x_d, htot_c;
    logic [VW-1:0] y_q, y_d, vtot_c;
    logic          x_last, y_last, hwrap, fwrap;

    // registered outputs
    logic hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
    logic lp_q, lp_d, fp_q, fp_d, fetch_q, fetch_d;

    // decode helpers on the next raster position
    logic [HW-1:0] hact_n, hsa_n, hse_n, htot_n;
    logic [VW-1:0] vact_n, vsa_n, vse_n, vtot_n, y_nx;

    // counter advance and frame-boundary config handoff
    always_comb begin
        htot_c = hsum(ah_q);
        vtot_c = vsum(av_q);
        // >= keeps the raster wrapping even for degenerate totals
        x_last = (x_q >= htot_c - H1);
        y_last = (y_q >= vtot_c - V1);
        hwrap  = pix_en & x_last;
        fwrap  = hwrap & y_last;
        x_d    = x_q;
        y_d    = y_q;
        if (pix_en) begin
            x_d = x_last ? '0 : x_q + H1;
        end
        if (hwrap) begin
            y_d = y_last ? '0 : y_q + V1;
        end
        ah_d   = ah_q;
        av_d   = av_q;
        apol_d = apol_q;
        ph_d   = ph_q;
        pv_d   = pv_q;
        ppol_d = ppol_q;
        pend_d = pend_q;
        if (fwrap && pend_q) begin
            ah_d   = ph_q;
            av_d   = pv_q;
            apol_d = ppol_q;
            pend_d = 1'b0;
        end else if (cfg_valid && !pend_q) begin
            ph_d   = cfg_h;
            pv_d   = cfg_v;
            ppol_d = cfg_pol;
            pend_d = 1'b1;
        end
    end

    // region decode for the position and timing the raster moves to
    always_comb begin
        hact_n  = ah_d[4*HW-1-:HW];
        hsa_n   = hact_n + ah_d[3*HW-1-:HW];
        hse_n   = hsa_n + ah_d[2*HW-1-:HW];
        htot_n  = hse_n + ah_d[HW-1:0];
        vact_n  = av_d[4*VW-1-:VW];
        vsa_n   = vact_n + av_d[3*VW-1-:VW];
        vse_n   = vsa_n + av_d[2*VW-1-:VW];
        vtot_n  = vse_n + av_d[VW-1:0];
        y_nx    = (y_d >= vtot_n - V1) ? '0 : y_d + V1;
        hs_d    = (x_d >= hsa_n && x_d < hse_n) ? apol_d[1] : ~apol_d[1];
        vs_d    = (y_d >= vsa_n && y_d < vse_n) ? apol_d[0] : ~apol_d[0];
        blank_d = ~((x_d < hact_n) && (y_d < vact_n));
        lp_d    = (x_d == '0);
        fp_d    = lp_d && (y_d == '0);
        fetch_d = (x_d == htot_n - LA) && (y_nx < vact_n);
    end

    // state and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ah_q    <= DEF_H;
            av_q    <= DEF_V;
            apol_q  <= DEF_POL;
            ph_q    <= '0;
            pv_q    <= '0;
            ppol_q  <= '0;
            pend_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            hs_q    <= ~DEF_POL[1];
            vs_q    <= ~DEF_POL[0];
            blank_q <= 1'b0;
            lp_q    <= 1'b1;
            fp_q    <= 1'b1;
            fetch_q <= 1'b0;
        end else begin
            ah_q    <= ah_d;
            av_q    <= av_d;
            apol_q  <= apol_d;
            ph_q    <= ph_d;
            pv_q    <= pv_d;
            ppol_q  <= ppol_d;
            pend_q  <= pend_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            lp_q    <= lp_d;
            fp_q    <= fp_d;
            fetch_q <= fetch_d;
        end
    end

    assign cfg_ready   = ~pend_q;
    assign cfg_pending = pend_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign blank       = blank_q;
    assign de          = ~blank_q;
    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign line_pulse  = lp_q;
    assign frame_pulse = fp_q;
    assign fetch_pulse = fetch_q;

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] fcnt_q, fcnt_d;

    // clear wins over the frame-wrap increment
    always_comb begin
        fcnt_d = fcnt_q;
        if (frame_cnt_clr) begin
            fcnt_d = '0;
        end else if (fwrap) begin
            fcnt_d = fcnt_q + 16'd1;
        end
    end

    // frame counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign frame_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_prog.sv
// Directed bench for vga_timing_prog: default timing, small reprogrammed
// timing, frame-boundary handoff, pix_en gating and mid-frame reset.
module tb_vga_timing_prog;

    localparam int HW = 11;
    localparam int VW = 10;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            pix_en;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [4*HW-1:0] cfg_h;
    logic [4*VW-1:0] cfg_v;
    logic [1:0]      cfg_pol;
    logic            cfg_pending;
    logic            hsync, vsync, blank, de;
    logic [HW-1:0]   x_pos;
    logic [VW-1:0]   y_pos;
    logic            line_pulse, frame_pulse, fetch_pulse;
`ifdef VGA_FRAME_COUNT_EN
    logic            frame_cnt_clr;
    logic [15:0]     frame_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // horizontal defaults kept; vertical shrunk to 4/1/1/2 so a frame is 6400 cycles
    vga_timing_prog #(
        .HW(HW), .VW(VW), .LOOKAHEAD(4),
        .DEF_HACT(640), .DEF_HFP(16), .DEF_HSYNC(96), .DEF_HBP(48),
        .DEF_VACT(4), .DEF_VFP(1), .DEF_VSYNC(1), .DEF_VBP(2),
        .DEF_HPOL(0), .DEF_VPOL(0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .pix_en(pix_en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_h(cfg_h),
        .cfg_v(cfg_v),
        .cfg_pol(cfg_pol),
        .cfg_pending(cfg_pending),
        .hsync(hsync),
        .vsync(vsync),
        .blank(blank),
        .de(de),
        .x_pos(x_pos),
        .y_pos(y_pos),
        .line_pulse(line_pulse),
        .frame_pulse(frame_pulse),
        .fetch_pulse(fetch_pulse)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_cnt_clr(frame_cnt_clr),
        .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         adv;
        int         x;
        int         y;
        logic [5:0] e;
    } vec_t;

    vec_t tab[40];

    function automatic vec_t mk(input int a, input int x, input int y,
                                input logic [5:0] e);
        vec_t v;
        v.adv = a;
        v.x   = x;
        v.y   = y;
        v.e   = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".x"}, x_pos, 0);
        chk({tag, ".y"}, y_pos, 0);
        chk({tag, ".blank"}, blank, 0);
        chk({tag, ".de"}, de, 1);
        chk({tag, ".hsync"}, hsync, 1);
        chk({tag, ".vsync"}, vsync, 1);
        chk({tag, ".line"}, line_pulse, 1);
        chk({tag, ".frame"}, frame_pulse, 1);
        chk({tag, ".fetch"}, fetch_pulse, 0);
        chk({tag, ".ready"}, cfg_ready, 1);
        chk({tag, ".pending"}, cfg_pending, 0);
    endtask

    // e = {hsync, vsync, de, line, frame, fetch}
    task automatic run_tab(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            adv(tab[i].adv);
            chk($sformatf("v%0d.x", i), x_pos, tab[i].x);
            chk($sformatf("v%0d.y", i), y_pos, tab[i].y);
            chk($sformatf("v%0d.hsync", i), hsync, tab[i].e[5]);
            chk($sformatf("v%0d.vsync", i), vsync, tab[i].e[4]);
            chk($sformatf("v%0d.de", i), de, tab[i].e[3]);
            chk($sformatf("v%0d.blank", i), blank, !tab[i].e[3]);
            chk($sformatf("v%0d.line", i), line_pulse, tab[i].e[2]);
            chk($sformatf("v%0d.frame", i), frame_pulse, tab[i].e[1]);
            chk($sformatf("v%0d.fetch", i), fetch_pulse, tab[i].e[0]);
        end
    endtask

    localparam logic [4*HW-1:0] SMALL_H = {11'd8, 11'd1, 11'd2, 11'd1};
    localparam logic [4*VW-1:0] SMALL_V = {10'd4, 10'd1, 10'd1, 10'd1};

    initial begin
        int  n;
        int  nfetch;
        bit  ok;
        bit  en;
        int  ex;
        int  ey;

        // default timing, htotal 800, vtotal 8
        tab[0]  = mk(0,    0,   0, 6'b111110);
        tab[1]  = mk(639,  639, 0, 6'b111000);
        tab[2]  = mk(1,    640, 0, 6'b110000);
        tab[3]  = mk(15,   655, 0, 6'b110000);
        tab[4]  = mk(1,    656, 0, 6'b010000);
        tab[5]  = mk(95,   751, 0, 6'b010000);
        tab[6]  = mk(1,    752, 0, 6'b110000);
        tab[7]  = mk(44,   796, 0, 6'b110001);
        tab[8]  = mk(1,    797, 0, 6'b110000);
        tab[9]  = mk(3,    0,   1, 6'b111100);
        tab[10] = mk(1596, 796, 2, 6'b110001);
        tab[11] = mk(800,  796, 3, 6'b110000);
        tab[12] = mk(4,    0,   4, 6'b110100);
        tab[13] = mk(800,  0,   5, 6'b100100);
        tab[14] = mk(800,  0,   6, 6'b110100);
        tab[15] = mk(1596, 796, 7, 6'b110001);
        tab[16] = mk(3,    799, 7, 6'b110000);
        tab[17] = mk(1,    0,   0, 6'b111110);
        // small timing 8/1/2/1 x 4/1/1/1, positive polarities
        tab[18] = mk(0,  0,  0, 6'b001110);
        tab[19] = mk(7,  7,  0, 6'b001000);
        tab[20] = mk(1,  8,  0, 6'b000001);
        tab[21] = mk(1,  9,  0, 6'b100000);
        tab[22] = mk(1,  10, 0, 6'b100000);
        tab[23] = mk(1,  11, 0, 6'b000000);
        tab[24] = mk(1,  0,  1, 6'b001100);
        tab[25] = mk(20, 8,  2, 6'b000001);
        tab[26] = mk(12, 8,  3, 6'b000000);
        tab[27] = mk(4,  0,  4, 6'b000100);
        tab[28] = mk(12, 0,  5, 6'b010100);
        tab[29] = mk(9,  9,  5, 6'b110000);
        tab[30] = mk(3,  0,  6, 6'b000100);
        tab[31] = mk(8,  8,  6, 6'b000001);
        tab[32] = mk(4,  0,  0, 6'b001110);

        reset_n   = 1'b0;
        pix_en    = 1'b0;
        cfg_valid = 1'b0;
        cfg_h     = '0;
        cfg_v     = '0;
        cfg_pol   = 2'b00;
`ifdef VGA_FRAME_COUNT_EN
        frame_cnt_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst0");
        reset_n = 1'b1;
        pix_en  = 1'b1;

        run_tab(0, 17);

        n = 0;
        while (n == 0 || (!frame_pulse && n < 7000)) begin
            adv(1);
            n++;
        end
        chk("dflt_frame_period", n, 6400);

        // offer new timing mid-frame, then a second offer that must be refused
        adv(100);
        cfg_valid = 1'b1;
        cfg_h     = SMALL_H;
        cfg_v     = SMALL_V;
        cfg_pol   = 2'b11;
        adv(1);
        chk("cfg_pending_set", cfg_pending, 1);
        chk("cfg_ready_low", cfg_ready, 0);
        cfg_h   = {11'd100, 11'd10, 11'd10, 11'd10};
        cfg_v   = {10'd20, 10'd2, 10'd2, 10'd2};
        cfg_pol = 2'b00;
        adv(5);
        cfg_valid = 1'b0;
        n  = 0;
        ok = 1'b1;
        while (!frame_pulse && n < 7000) begin
            if (!cfg_pending || cfg_ready) ok = 1'b0;
            adv(1);
            n++;
        end
        chk("old_timing_to_wrap", n, 6294);
        chk("pending_held", ok, 1);
        chk("pending_cleared", cfg_pending, 0);
        chk("ready_restored", cfg_ready, 1);

        run_tab(18, 32);

        n      = 0;
        nfetch = 0;
        while (n == 0 || (!frame_pulse && n < 200)) begin
            adv(1);
            n++;
            nfetch += int'(fetch_pulse);
        end
        chk("small_frame_period", n, 84);
        chk("small_fetch_count", nfetch, 4);

        // pix_en pattern 1,0,0,1 from (1,0)
        adv(1);
        ex = 1;
        ey = 0;
        for (int i = 0; i < 24; i++) begin
            en     = (i % 4 == 0) || (i % 4 == 3);
            pix_en = en;
            @(posedge clk);
            #1;
            if (en) begin
                if (ex == 11) begin
                    ex = 0;
                    ey = (ey == 6) ? 0 : ey + 1;
                end else begin
                    ex++;
                end
            end
            chk($sformatf("gate%0d.x", i), x_pos, ex);
            chk($sformatf("gate%0d.line", i), line_pulse, ex == 0);
            chk($sformatf("gate%0d.hsync", i), hsync, ex >= 9 && ex <= 10);
        end
        pix_en = 1'b1;
        chk("gate_end.x", x_pos, 1);
        chk("gate_end.y", y_pos, 1);

        // reset with a pending config mid-frame
        cfg_valid = 1'b1;
        cfg_h     = SMALL_H;
        cfg_v     = SMALL_V;
        cfg_pol   = 2'b00;
        adv(1);
        cfg_valid = 1'b0;
        chk("pend_before_rst", cfg_pending, 1);
        adv(2);
        reset_n = 1'b0;
        #1;
        check_reset("rst_async");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        adv(656);
        chk("post_rst.x", x_pos, 656);
        chk("post_rst.hsync", hsync, 0);
        chk("post_rst.de", de, 0);
        n  = 0;
        ok = 1'b1;
        while (!frame_pulse && n < 7000) begin
            if (cfg_pending) ok = 1'b0;
            adv(1);
            n++;
        end
        chk("post_rst_to_wrap", n, 5744);
        chk("post_rst_no_pend", ok, 1);
        chk("post_rst_wrap.hsync", hsync, 1);

`ifdef VGA_FRAME_COUNT_EN
        chk("fcnt_1", frame_cnt, 1);
        adv(12800);
        chk("fcnt_3", frame_cnt, 3);
        adv(6399);
        frame_cnt_clr = 1'b1;
        adv(1);
        frame_cnt_clr = 1'b0;
        chk("fcnt_clr_on_wrap", frame_cnt, 0);
        adv(6400);
        chk("fcnt_after_clr", frame_cnt, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_prog.md
Name: vga_timing_prog

Overview:
- Programmable VGA/DVI raster timing generator; successor to the fixed-parameter vga block.
- Produces sync, blank and data-enable, pixel/line coordinates, and line/frame/fetch strobes.
- Timing and sync polarities are loaded at runtime through a valid/ready config port and take effect only at a frame boundary.
- Sits between the pixel clock domain and the pixel pipeline (RLE decoder, line buffer).

Parameters:
- HW, 11, bit width of horizontal counter and horizontal config fields
- VW, 10, bit width of vertical counter and vertical config fields
- LOOKAHEAD, 4, cycles before line start at which fetch_pulse fires (1..h_back)
- DEF_HACT/DEF_HFP/DEF_HSYNC/DEF_HBP, 640/16/96/48, reset horizontal timing
- DEF_VACT/DEF_VFP/DEF_VSYNC/DEF_VBP, 480/10/2/33, reset vertical timing
- DEF_HPOL/DEF_VPOL, 0/0, reset sync polarity (0 = active-low)

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- pix_en  in  1  clock enable; counters advance only when high
- cfg_valid  in  1  config offered
- cfg_ready  out  1  high when the pending slot is empty
- cfg_h  in  4*HW  {hact,hfp,hsync,hbp}, MSB first
- cfg_v  in  4*VW  {vact,vfp,vsync,vbp}, MSB first
- cfg_pol  in  2  {hpol,vpol}
- cfg_pending  out  1  config accepted but not yet applied
- hsync  out  1  horizontal sync at configured polarity
- vsync  out  1  vertical sync at configured polarity
- blank  out  1  high outside the active area
- de  out  1  equal to ~blank
- x_pos  out  HW  current pixel column
- y_pos  out  VW  current line
- line_pulse  out  1  one cycle at x_pos==0
- frame_pulse  out  1  one cycle at x_pos==0, y_pos==0
- fetch_pulse  out  1  one cycle, LOOKAHEAD cycles before an active line starts

Behaviour:
- Derived totals: htotal = hact+hfp+hsync+hbp; vtotal = vact+vfp+vsync+vbp. Sums are computed at HW/VW width; overflow is the programmer's responsibility.
- Counters:
  - x_pos runs 0..htotal-1 and wraps to 0.
  - y_pos increments on each x wrap and runs 0..vtotal-1.
  - Both advance only when pix_en=1. When pix_en=0, every output holds, and pulses extend for the frozen cycles.
- Region decode (on current x_pos/y_pos; all outputs registered and aligned with x_pos/y_pos in the same cycle):
  - hactive when x<hact; hsync region when hact+hfp <= x < hact+hfp+hsync.
  - vactive when y<vact; vsync region when vact+vfp <= y < vact+vfp+vsync.
  - blank = ~(hactive & vactive).
  - hsync output = region ? hpol : ~hpol; vsync likewise with vpol.
- fetch_pulse: high when x_pos == htotal-LOOKAHEAD and the next line is active, i.e. (y_pos+1)%vtotal < vact. Fires for line 0 from line vtotal-1. It fires vact times per frame.
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready; the inputs are copied into the pending register.
  - cfg_ready = ~cfg_pending.
  - Applied registers take the pending values on the pix_en cycle where x wraps and y wraps (next frame start). cfg_pending clears in that same cycle. The first frame using the new timing starts with frame_pulse at the new config.
  - A transfer arriving in the apply cycle is blocked because cfg_ready=0; it can be offered again the next cycle.
- Reset (asynchronous, any time, including mid-line or mid-frame):
  - x_pos=0, y_pos=0, applied config = DEF_*, pending cleared, cfg_ready=1.
  - blank=0, de=1, hsync=~DEF_HPOL, vsync=~DEF_VPOL.
  - line_pulse=1 and frame_pulse=1, since the raster is at (0,0).
  - fetch_pulse=0.
  - First pixel after release is (0,0) of a fresh frame.
- Illegal configs (any field 0, or LOOKAHEAD > hbp+hsync+hfp) produce undefined waveforms but must never lock up: counters always wrap at htotal-1/vtotal-1.

Optional Feature:
- Macro VGA_FRAME_COUNT_EN.
- When defined, adds output frame_cnt [15:0]:
  - reset 0; increments on every frame wrap; wraps 0xFFFF->0.
  - Also adds input frame_cnt_clr, synchronous, with priority over increment.
- When undefined, neither port exists and no counter logic is built.

Test Plan:
- Reset defaults, pix_en=1 → hsync low for x=656..751, vsync low for y=490..491, de high only for x<640 & y<480, frame_pulse period exactly 420000 cycles.
- Small config hact/hfp/hsync/hbp=8/1/2/1, vact/vfp/vsync/vbp=4/1/1/1, pol=11 → htotal 12, vtotal 7. hsync high at x=9..10. fetch_pulse at x=8 on y=6,0,1,2 only.
- Config offered mid-frame → cfg_pending=1 and cfg_ready=0 until the frame wrap. The old timing persists to the end of the frame, and the new timing starts exactly at the next frame_pulse. A second cfg_valid during pending is not accepted.
- pix_en toggled 1,0,0,1 repeatedly → x_pos advances one per enabled cycle and all outputs hold while disabled. Line-to-line period is 2*htotal cycles when pix_en is a 50% pattern.
- Assert reset_n low at x=300, y=200 with a config pending → outputs immediately return to reset values, the pending config is discarded, and the default timing resumes from (0,0).
- VGA_FRAME_COUNT_EN, small config → frame_cnt=3 after 3 wraps. frame_cnt_clr asserted in a wrap cycle gives 0.
